// File: rtl/mmcm_ps_pkg.sv
// Shared types and constants for the MMCM fine phase-shift controller.
package mmcm_ps_pkg;

    localparam int PHASE_W         = 9;
    localparam int DEFAULT_TIMEOUT = 64;

    typedef logic signed [PHASE_W-1:0] phase_t;
    typedef logic [1:0]                state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_CMP  = 2'd1;
    localparam state_t ST_WAIT = 2'd2;

    // Keeps the psdone timer at least one bit wide for degenerate timeouts.
    function automatic int timer_width(input int timeout);
        return (timeout > 1) ? $clog2(timeout) : 1;
    endfunction

endpackage

// File: rtl/mmcm_phaseshift_ctrl_if.sv
// Register-side phase request and MMCM dynamic phase-shift port, bundled.
interface mmcm_phaseshift_ctrl_if;
    import mmcm_ps_pkg::*;

    phase_t value_i;
    logic   load_i;
    phase_t value_o;
    logic   done_o;
    logic   err_o;
    logic   psen_o;
    logic   psincdec_o;
    logic   psdone_i;
    logic   locked_i;

    modport slave (
        input  value_i, load_i, psdone_i, locked_i,
        output value_o, done_o, err_o, psen_o, psincdec_o
    );

    modport master (
        output value_i, load_i, psdone_i, locked_i,
        input  value_o, done_o, err_o, psen_o, psincdec_o
    );

endinterface

// File: rtl/mmcm_phaseshift_ctrl.sv
// Walks the MMCM fine phase shift one step at a time toward a requested target,
// re-walking from zero after a loss of lock and flagging a missing psdone.
module mmcm_phaseshift_ctrl
    import mmcm_ps_pkg::*;
#(
    parameter phase_t pDEFAULT = '0,
    parameter int     pTIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                  clk_usb,
    input  logic                  reset_n,
    mmcm_phaseshift_ctrl_if.slave bus
);

    localparam int             TW         = timer_width(pTIMEOUT);
    localparam logic [TW-1:0]  TIMER_LAST = TW'(pTIMEOUT - 1);

    state_t         state;
    phase_t         target;
    phase_t         actual;
    logic [TW-1:0]  timer;
    logic           done;
    logic           err;
    logic           psen;
    logic           incdec;

    assign bus.value_o    = actual;
    assign bus.done_o     = done;
    assign bus.err_o      = err;
    assign bus.psen_o     = psen;
    assign bus.psincdec_o = incdec;

    always_ff @(posedge clk_usb) begin
        if (!reset_n) begin
            state  <= ST_CMP;
            target <= pDEFAULT;
            actual <= '0;
            timer  <= '0;
            done   <= 1'b0;
            err    <= 1'b0;
            psen   <= 1'b0;
            incdec <= 1'b0;
        end else begin
            psen <= 1'b0;

            if (bus.load_i) begin
                target <= bus.value_i;
                done   <= 1'b0;
                err    <= 1'b0;
            end

            // NOTE: several non-blocking assignments to one register in a block
            // are legal; the last one executed wins, which encodes priority here.
            if (!bus.locked_i) begin
                // An MMCM that lost lock resets, zeroing its applied phase.
                actual <= '0;
                done   <= 1'b0;
                state  <= ST_CMP;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (bus.load_i) state <= ST_CMP;
                    end

                    ST_CMP: begin
                        // A fresh load re-evaluates against the new target next cycle.
                        if (!bus.load_i) begin
                            if (actual == target) begin
                                done  <= 1'b1;
                                state <= ST_IDLE;
                            end else begin
                                psen   <= 1'b1;
                                incdec <= (target > actual);
                                timer  <= '0;
                                state  <= ST_WAIT;
                            end
                        end
                    end

                    ST_WAIT: begin
                        if (bus.psdone_i) begin
                            actual <= incdec ? actual + phase_t'(1) : actual - phase_t'(1);
                            state  <= ST_CMP;
                        end else if (timer == TIMER_LAST) begin
                            if (bus.load_i) begin
                                state <= ST_CMP;
                            end else begin
                                err   <= 1'b1;
                                done  <= 1'b1;
                                state <= ST_IDLE;
                            end
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end

                    default: state <= ST_CMP;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mmcm_phaseshift_ctrl.sv
// Bench for mmcm_phaseshift_ctrl: MMCM psdone model plus a step-count reference.
module tb_mmcm_phaseshift_ctrl;
    import mmcm_ps_pkg::*;

    localparam int TIMEOUT = 64;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    mmcm_phaseshift_ctrl_if bus ();

    mmcm_phaseshift_ctrl #(
        .pDEFAULT (phase_t'(0)),
        .pTIMEOUT (TIMEOUT)
    ) dut (
        .clk_usb (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_cmp = 0;
    int n_mis = 0;

    int cyc          = 0;
    int lat          = 12;
    bit drop_psdone  = 1'b0;
    int load_cyc     = 0;
    int cur_ref      = 0;

    int inc_cnt      = 0;
    int dec_cnt      = 0;
    int consec_viol  = 0;
    int overlap_viol = 0;
    int unl_pulses   = 0;
    int last_psen_cyc = 0;
    bit prev_psen    = 1'b0;
    bit pending      = 1'b0;
    int due          = 0;
    int last_val     = 100000;
    int val_q[$];

    always @(posedge clk) cyc++;

    // MMCM model and output monitor: psdone answers lat cycles after a psen pulse.
    always @(negedge clk) begin
        if (bus.psen_o === 1'b1) begin
            if (bus.psincdec_o === 1'b1) inc_cnt++;
            else dec_cnt++;
            if (prev_psen) consec_viol++;
            if (pending) overlap_viol++;
            if (bus.locked_i !== 1'b1) unl_pulses++;
            last_psen_cyc = cyc;
            if (!drop_psdone) begin
                pending = 1'b1;
                due     = cyc + lat;
            end
        end
        prev_psen = (bus.psen_o === 1'b1);
        if (bus.locked_i !== 1'b1) pending = 1'b0;
        if (pending && cyc == due) begin
            bus.psdone_i = 1'b1;
            pending      = 1'b0;
        end else begin
            bus.psdone_i = 1'b0;
        end
        if (int'(bus.value_o) != last_val) begin
            last_val = int'(bus.value_o);
            val_q.push_back(last_val);
        end
    end

    task automatic do_load(input int v);
        bus.value_i = phase_t'(v);
        bus.load_i  = 1'b1;
        @(negedge clk);
        bus.load_i  = 1'b0;
        load_cyc    = cyc;
    endtask

    task automatic wait_done(input int budget, output int took);
        took = -1;
        for (int i = 0; i <= budget; i++) begin
            if (bus.done_o === 1'b1) begin
                took = cyc - load_cyc;
                break;
            end
            @(negedge clk);
        end
        n_cmp++;
        if (took < 0) begin
            n_mis++;
            $display("FAIL wait_done: done_o still low after %0d cycles", budget);
        end
    endtask

    task automatic test_reset();
        int base;
        bus.value_i  = '0;
        bus.load_i   = 1'b0;
        bus.locked_i = 1'b1;
        reset_n      = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (bus.value_o !== phase_t'(0)) begin n_mis++; $display("FAIL reset_value: got %0d want 0", bus.value_o); end
        n_cmp++; if (bus.done_o !== 1'b0) begin n_mis++; $display("FAIL reset_done: got %b want 0", bus.done_o); end
        n_cmp++; if (bus.err_o !== 1'b0) begin n_mis++; $display("FAIL reset_err: got %b want 0", bus.err_o); end
        n_cmp++; if (bus.psen_o !== 1'b0 || bus.psincdec_o !== 1'b0) begin n_mis++; $display("FAIL reset_ps: got psen=%b incdec=%b want 0/0", bus.psen_o, bus.psincdec_o); end
        base    = inc_cnt + dec_cnt;
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if (bus.done_o !== 1'b1) begin n_mis++; $display("FAIL reset_release_done: got %b want 1", bus.done_o); end
        repeat (4) @(negedge clk);
        n_cmp++; if (inc_cnt + dec_cnt != base) begin n_mis++; $display("FAIL reset_no_psen: got %0d pulses want 0", inc_cnt + dec_cnt - base); end
        cur_ref = 0;
    endtask

    task automatic test_walk_up();
        int bi, bd, qs, took;
        int exp_q[$];
        bit seq_ok;
        lat = 12;
        bi = inc_cnt; bd = dec_cnt; qs = val_q.size();
        for (int v = cur_ref + 1; v <= 3; v++) exp_q.push_back(v);
        do_load(3);
        wait_done(3 * (lat + 2) + 60, took);
        n_cmp++; if (took != 43) begin n_mis++; $display("FAIL up_latency: got %0d want 43", took); end
        n_cmp++; if (bus.value_o !== phase_t'(3)) begin n_mis++; $display("FAIL up_value: got %0d want 3", bus.value_o); end
        n_cmp++; if (inc_cnt - bi != 3 || dec_cnt - bd != 0) begin n_mis++; $display("FAIL up_pulses: got inc=%0d dec=%0d want 3/0", inc_cnt - bi, dec_cnt - bd); end
        seq_ok = (val_q.size() - qs == exp_q.size());
        for (int i = 0; seq_ok && i < exp_q.size(); i++) if (val_q[qs + i] != exp_q[i]) seq_ok = 1'b0;
        n_cmp++; if (!seq_ok) begin n_mis++; $display("FAIL up_sequence: got %0d value changes want %0d (1,2,3)", val_q.size() - qs, exp_q.size()); end
        cur_ref = 3;
    endtask

    task automatic test_walk_down();
        int bi, bd, qs, took;
        int exp_q[$];
        bit seq_ok;
        bi = inc_cnt; bd = dec_cnt; qs = val_q.size();
        for (int v = cur_ref - 1; v >= -2; v--) exp_q.push_back(v);
        do_load(-2);
        wait_done(5 * (lat + 2) + 60, took);
        n_cmp++; if (took != 5 * (lat + 2) + 1) begin n_mis++; $display("FAIL down_latency: got %0d want %0d", took, 5 * (lat + 2) + 1); end
        n_cmp++; if (bus.value_o !== phase_t'(-2)) begin n_mis++; $display("FAIL down_value: got %0d want -2", bus.value_o); end
        n_cmp++; if (inc_cnt - bi != 0 || dec_cnt - bd != 5) begin n_mis++; $display("FAIL down_pulses: got inc=%0d dec=%0d want 0/5", inc_cnt - bi, dec_cnt - bd); end
        seq_ok = (val_q.size() - qs == exp_q.size());
        for (int i = 0; seq_ok && i < exp_q.size(); i++) if (val_q[qs + i] != exp_q[i]) seq_ok = 1'b0;
        n_cmp++; if (!seq_ok) begin n_mis++; $display("FAIL down_sequence: got %0d value changes want 5", val_q.size() - qs); end
        cur_ref = -2;
    endtask

    task automatic test_timeout();
        int bi, took;
        drop_psdone = 1'b1;
        bi = inc_cnt + dec_cnt;
        do_load(5);
        wait_done(TIMEOUT + 40, took);
        n_cmp++; if (bus.err_o !== 1'b1) begin n_mis++; $display("FAIL timeout_err: got %b want 1", bus.err_o); end
        n_cmp++; if (load_cyc + took - last_psen_cyc != TIMEOUT) begin n_mis++; $display("FAIL timeout_delay: got %0d want %0d", load_cyc + took - last_psen_cyc, TIMEOUT); end
        n_cmp++; if (bus.value_o !== phase_t'(cur_ref)) begin n_mis++; $display("FAIL timeout_value: got %0d want %0d", bus.value_o, cur_ref); end
        n_cmp++; if (inc_cnt + dec_cnt - bi != 1) begin n_mis++; $display("FAIL timeout_pulses: got %0d want 1", inc_cnt + dec_cnt - bi); end
        drop_psdone = 1'b0;
        do_load(cur_ref);
        n_cmp++; if (bus.err_o !== 1'b0 || bus.done_o !== 1'b0) begin n_mis++; $display("FAIL reload_clear: got err=%b done=%b want 0/0", bus.err_o, bus.done_o); end
        wait_done(20, took);
        n_cmp++; if (took != 1) begin n_mis++; $display("FAIL zero_move_latency: got %0d want 1", took); end
    endtask

    task automatic test_lock_loss();
        int bi, bu, took;
        bit found;
        lat = 12;
        do_load(0);
        wait_done(4 * (lat + 2) + 60, took);
        cur_ref = 0;
        do_load(5);
        found = 1'b0;
        for (int i = 0; i < 500 && !found; i++) begin
            @(negedge clk);
            if (bus.psen_o === 1'b1 && bus.value_o === phase_t'(2)) found = 1'b1;
        end
        n_cmp++; if (!found) begin n_mis++; $display("FAIL lock_reach_2: got value %0d want step from 2", bus.value_o); end
        repeat (3) @(negedge clk);
        bu = unl_pulses;
        bus.locked_i = 1'b0;
        @(negedge clk);
        n_cmp++; if (bus.value_o !== phase_t'(0)) begin n_mis++; $display("FAIL lock_drop_value: got %0d want 0", bus.value_o); end
        repeat (30) @(negedge clk);
        n_cmp++; if (bus.done_o !== 1'b0 || unl_pulses != bu) begin n_mis++; $display("FAIL unlocked_idle: got done=%b pulses=%0d want 0/0", bus.done_o, unl_pulses - bu); end
        bi = inc_cnt;
        bus.locked_i = 1'b1;
        load_cyc = cyc;
        wait_done(5 * (lat + 2) + 60, took);
        n_cmp++; if (inc_cnt - bi != 5) begin n_mis++; $display("FAIL relock_pulses: got %0d want 5", inc_cnt - bi); end
        n_cmp++; if (bus.value_o !== phase_t'(5)) begin n_mis++; $display("FAIL relock_value: got %0d want 5", bus.value_o); end
        cur_ref = 5;
    endtask

    task automatic test_retarget();
        int bi, bd, qs, took, mx, e;
        int exp_q[$];
        bit found, seq_ok;
        lat = 6;
        do_load(0);
        wait_done(6 * (lat + 2) + 60, took);
        cur_ref = 0;
        // Retarget 10 -> 4 while the walk sits between steps at 2.
        bi = inc_cnt; bd = dec_cnt; qs = val_q.size();
        do_load(10);
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            if (bus.value_o === phase_t'(2)) found = 1'b1;
            else @(negedge clk);
        end
        do_load(4);
        wait_done(4 * (lat + 2) + 60, took);
        mx = -1000;
        for (int i = qs; i < val_q.size(); i++) if (val_q[i] > mx) mx = val_q[i];
        n_cmp++; if (!found || bus.value_o !== phase_t'(4) || mx != 4) begin n_mis++; $display("FAIL retarget_cmp: got value=%0d max=%0d want 4/4", bus.value_o, mx); end
        n_cmp++; if (inc_cnt - bi != 4 || dec_cnt - bd != 0) begin n_mis++; $display("FAIL retarget_cmp_pulses: got inc=%0d dec=%0d want 4/0", inc_cnt - bi, dec_cnt - bd); end
        // Retarget 10 -> 5 on the very cycle the 6->7 step's psdone is sampled.
        cur_ref = 4;
        bi = inc_cnt; bd = dec_cnt; qs = val_q.size();
        do_load(10);
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            @(negedge clk);
            if (bus.psen_o === 1'b1 && bus.value_o === phase_t'(6)) found = 1'b1;
        end
        repeat (lat) @(negedge clk);
        do_load(5);
        wait_done(4 * (lat + 2) + 60, took);
        for (e = cur_ref + 1; e <= 7; e++) exp_q.push_back(e);
        for (e = 6; e >= 5; e--) exp_q.push_back(e);
        seq_ok = found && (val_q.size() - qs == exp_q.size());
        for (int i = 0; seq_ok && i < exp_q.size(); i++) if (val_q[qs + i] != exp_q[i]) seq_ok = 1'b0;
        n_cmp++; if (!seq_ok || bus.value_o !== phase_t'(5)) begin n_mis++; $display("FAIL retarget_coincident: got value=%0d changes=%0d want 5 via 5,6,7,6,5", bus.value_o, val_q.size() - qs); end
        n_cmp++; if (inc_cnt - bi != 3 || dec_cnt - bd != 2) begin n_mis++; $display("FAIL retarget_coincident_pulses: got inc=%0d dec=%0d want 3/2", inc_cnt - bi, dec_cnt - bd); end
        cur_ref = 5;
    endtask

    task automatic test_random();
        int bi, bd, took, t, n, exp_inc, exp_dec;
        for (int it = 0; it < 10; it++) begin
            lat = int'($urandom_range(1, 16));
            t   = int'($urandom_range(0, 80)) - 40;
            n   = (t > cur_ref) ? t - cur_ref : cur_ref - t;
            exp_inc = (t > cur_ref) ? n : 0;
            exp_dec = (t < cur_ref) ? n : 0;
            bi = inc_cnt; bd = dec_cnt;
            do_load(t);
            wait_done(n * (lat + 2) + 60, took);
            n_cmp++; if (took != n * (lat + 2) + 1) begin n_mis++; $display("FAIL rand_latency[%0d]: got %0d want %0d (L=%0d n=%0d)", it, took, n * (lat + 2) + 1, lat, n); end
            n_cmp++; if (bus.value_o !== phase_t'(t) || bus.err_o !== 1'b0) begin n_mis++; $display("FAIL rand_value[%0d]: got %0d err=%b want %0d err=0", it, bus.value_o, bus.err_o, t); end
            n_cmp++; if (inc_cnt - bi != exp_inc || dec_cnt - bd != exp_dec) begin n_mis++; $display("FAIL rand_pulses[%0d]: got inc=%0d dec=%0d want %0d/%0d", it, inc_cnt - bi, dec_cnt - bd, exp_inc, exp_dec); end
            cur_ref = t;
        end
    endtask

    task automatic test_protocol();
        n_cmp++; if (consec_viol != 0) begin n_mis++; $display("FAIL psen_back_to_back: got %0d want 0", consec_viol); end
        n_cmp++; if (overlap_viol != 0) begin n_mis++; $display("FAIL psen_outstanding: got %0d want 0", overlap_viol); end
    endtask

    initial begin
        test_reset();
        test_walk_up();
        test_walk_down();
        test_timeout();
        test_lock_loss();
        test_retarget();
        test_random();
        test_protocol();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
